fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of decode/control.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions with their PC tag in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Accepts taken jump/branch redirects from execute; squashes wrong-path responses still in flight.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam int PC_INCR = 4;
  localparam int ENTRY_AWIDTH = 32;
  localparam int ENTRY_DWIDTH = 32;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
  typedef struct packed {
    logic [ENTRY_AWIDTH-1:0] pc;
    logic [ENTRY_DWIDTH-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries with same-cycle push/pop and clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  fetch_entry_t                 i_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output fetch_entry_t                 o_head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = i_pop && r_cnt != '0;
  assign w_push = i_push && (r_cnt != CW'(DEPTH) || w_pop);
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_count = r_cnt;
  assign o_head = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_data;
  end
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      r_rd <= !w_pop ? r_rd : r_rd == PW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
      r_wr <= !w_push ? r_wr : r_wr == PW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing in-order imem requests, 2-entry decode queue, redirect squash.
// Defining FETCH_PERF_EN adds fetch_count_o / flush_count_o performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int                DEPTH    = FETCH_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_count_o,
  output logic [31:0]       flush_count_o,
`endif
  output logic [AWIDTH-1:0] pc_o
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_e r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_pc, w_pc_nxt;
  logic [CW-1:0] r_outst, w_outst_nxt, r_drop, w_drop_nxt;
  logic [CW-1:0] w_tag_cnt, w_out_cnt;
  logic [CW:0] w_used;
  logic w_accept, w_run_rsp, w_pop;
  logic w_tag_full, w_tag_empty, w_out_full, w_out_empty;
  fetch_entry_t w_tag_in, w_tag_head, w_out_in, w_out_head;

  // A head leaving this cycle frees its slot, which sustains one fetch per cycle.
  assign w_used = {1'b0, r_outst} + {1'b0, w_out_cnt} - {{CW{1'b0}}, w_pop};
  assign imem_req_valid_o = !reset && !redirect_i && r_state == RUN && w_used < (CW+1)'(DEPTH);
  assign imem_addr_o = r_pc;
  assign w_accept = imem_req_valid_o && imem_req_ready_i;
  assign w_run_rsp = imem_rsp_valid_i && r_state == RUN && !redirect_i;
  assign insn_valid_o = !w_out_empty && !redirect_i;
  assign w_pop = insn_valid_o && insn_ready_i;
  assign insn_o = w_out_empty ? '0 : w_out_head.insn;
  assign pc_o = w_out_empty ? '0 : w_out_head.pc;
  assign w_tag_in = '{pc: r_pc, insn: '0};
  // Tag entries carry a zero insn field, so OR-ing merges in the returned word.
  assign w_out_in = w_tag_head | fetch_entry_t'({{ENTRY_AWIDTH{1'b0}}, imem_rsp_data_i});

  always_comb begin
    w_pc_nxt = redirect_i ? {redirect_pc_i[AWIDTH-1:2], 2'b00} : w_accept ? r_pc + AWIDTH'(PC_INCR) : r_pc;
    w_outst_nxt = r_outst + CW'(w_accept) - CW'(imem_rsp_valid_i);
    w_drop_nxt = redirect_i ? w_outst_nxt : r_state == DRAIN ? r_drop - CW'(imem_rsp_valid_i) : r_drop;
    w_state_nxt = w_drop_nxt != '0 ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= BASEADDR;
      r_outst <= '0;
      r_drop <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      r_outst <= w_outst_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_accept),
    .i_pop   (w_run_rsp),
    .i_clear (redirect_i),
    .i_data  (w_tag_in),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_cnt),
    .o_head  (w_tag_head)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_out_q (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_run_rsp),
    .i_pop   (w_pop),
    .i_clear (redirect_i),
    .i_data  (w_out_in),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_cnt),
    .o_head  (w_out_head)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + 32'(w_pop);
      r_flush_cnt <= r_flush_cnt + 32'(redirect_i);
    end
  end
  assign fetch_count_o = r_fetch_cnt;
  assign flush_count_o = r_flush_cnt;
`endif

  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid_i |-> r_outst != '0);
  assert property (@(posedge clk) disable iff (reset) w_accept |-> !w_tag_full);
  assert property (@(posedge clk) disable iff (reset) w_run_rsp |-> !w_tag_empty && (!w_out_full || w_pop));
  assert property (@(posedge clk) disable iff (reset) r_state == RUN |-> w_tag_cnt == r_outst);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomised checks of fetch_unit against an in-order memory model.
module tb_fetch_unit;
  localparam logic [31:0] BASE = 32'h0100_0000;
  logic clk = 0, reset = 1, redirect_i = 0, imem_req_ready_i = 0;
  logic imem_rsp_valid_i = 0, insn_ready_i = 0;
  logic [31:0] redirect_pc_i = 0, imem_rsp_data_i = 0;
  logic imem_req_valid_o, insn_valid_o;
  logic [31:0] imem_addr_o, insn_o, pc_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_o, flush_count_o;
`endif
  int n_cmp = 0, n_bad = 0;
  bit mem_rand = 0;
  int mem_lat = 1;
  int cyc = 0, last_due = -1, due_c = 0;
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t pend[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .insn_valid_o(insn_valid_o),
    .insn_ready_i(insn_ready_i), .insn_o(insn_o),
`ifdef FETCH_PERF_EN
    .fetch_count_o(fetch_count_o), .flush_count_o(flush_count_o),
`endif
    .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // In-order memory: captures accepts at the edge, answers 1 or more cycles later.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend.delete();
      last_due = -1;
    end else if (imem_req_valid_o && imem_req_ready_i) begin
      due_c = cyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat) - 1;
      if (due_c <= last_due) due_c = last_due + 1;
      last_due = due_c;
      pend.push_back('{addr: imem_addr_o, due: due_c});
    end
    #1;
    imem_req_ready_i = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid_i = 1;
      imem_rsp_data_i = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid_i = 0;
      imem_rsp_data_i = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1;
    redirect_i = 0;
    insn_ready_i = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    step();
    reset = 1;
    redirect_i = 0;
    insn_ready_i = 1;
    step();
    step();
    sample();
    n_cmp++; if (insn_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_insn_valid got %b want 0", insn_valid_o); end
    n_cmp++; if (insn_o !== 32'h0) begin n_bad++; $display("FAIL reset_insn got %h want 0", insn_o); end
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", pc_o); end
    n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid_o); end
    n_cmp++; if (imem_addr_o !== BASE) begin n_bad++; $display("FAIL reset_addr got %h want %h", imem_addr_o, BASE); end
    step();
    reset = 0;
    sample();
    n_cmp++; if (imem_req_valid_o !== 1'b1) begin n_bad++; $display("FAIL first_req_valid got %b want 1", imem_req_valid_o); end
    n_cmp++; if (imem_addr_o !== BASE) begin n_bad++; $display("FAIL first_req_addr got %h want %h", imem_addr_o, BASE); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      sample();
      e = BASE + 32'(4 * (k - 2));
      if (k < 2) begin
        n_cmp++; if (insn_valid_o !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid cyc%0d got %b want 0", k, insn_valid_o); end
      end else begin
        n_cmp++; if (insn_valid_o !== 1'b1) begin n_bad++; $display("FAIL stream_valid cyc%0d got %b want 1", k, insn_valid_o); end
        n_cmp++; if (pc_o !== e) begin n_bad++; $display("FAIL stream_pc cyc%0d got %h want %h", k, pc_o, e); end
        n_cmp++; if (insn_o !== mem_word(e)) begin n_bad++; $display("FAIL stream_insn cyc%0d got %h want %h", k, insn_o, mem_word(e)); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    do_reset();
    for (int k = 1; k < 4; k++) step();
    for (int k = 4; k < 15; k++) begin
      step();
      insn_ready_i = k >= 9;
      sample();
      e = k < 9 ? BASE + 32'h8 : BASE + 32'h8 + 32'(4 * (k - 9));
      n_cmp++; if (insn_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_valid cyc%0d got %b want 1", k, insn_valid_o); end
      n_cmp++; if (pc_o !== e) begin n_bad++; $display("FAIL stall_pc cyc%0d got %h want %h", k, pc_o, e); end
      n_cmp++; if (insn_o !== mem_word(e)) begin n_bad++; $display("FAIL stall_insn cyc%0d got %h want %h", k, insn_o, mem_word(e)); end
      if (k < 9) begin
        n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_no_req cyc%0d got %b want 0", k, imem_req_valid_o); end
      end
      if (k == 9) begin
        n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== BASE + 32'h10) begin n_bad++; $display("FAIL stall_resume_req got %b/%h want 1/%h", imem_req_valid_o, imem_addr_o, BASE + 32'h10); end
      end
    end
  endtask

  task automatic test_redirect();
    bit seen = 0;
    mem_lat = 3;
    do_reset();
    step();
    step();
    redirect_i = 1;
    redirect_pc_i = 32'h0100_0102;
    sample();
    n_cmp++; if (insn_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin n_bad++; $display("FAIL redir_cycle got valid %b req %b want 0/0", insn_valid_o, imem_req_valid_o); end
    for (int k = 3; k < 5; k++) begin
      step();
      redirect_i = 0;
      sample();
      n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_no_req cyc%0d got %b want 0", k, imem_req_valid_o); end
      n_cmp++; if (imem_addr_o !== 32'h0100_0100) begin n_bad++; $display("FAIL drain_addr cyc%0d got %h want 01000100", k, imem_addr_o); end
    end
    step();
    sample();
    n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0100_0100) begin n_bad++; $display("FAIL redir_req got %b/%h want 1/01000100", imem_req_valid_o, imem_addr_o); end
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      sample();
      if (insn_valid_o) begin
        seen = 1;
        n_cmp++; if (pc_o !== 32'h0100_0100) begin n_bad++; $display("FAIL redir_pc got %h want 01000100", pc_o); end
        n_cmp++; if (insn_o !== mem_word(32'h0100_0100)) begin n_bad++; $display("FAIL redir_insn got %h want %h", insn_o, mem_word(32'h0100_0100)); end
      end
    end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL redir_timeout got no insn_valid want one within 10 cycles"); end
    mem_lat = 1;
  endtask

  task automatic test_collide();
    do_reset();
    for (int k = 1; k < 4; k++) step();
    step();
    redirect_i = 1;
    redirect_pc_i = 32'h0200_0010;
    sample();
    n_cmp++; if (insn_valid_o !== 1'b0) begin n_bad++; $display("FAIL collide_valid got %b want 0", insn_valid_o); end
    n_cmp++; if (imem_req_valid_o !== 1'b0) begin n_bad++; $display("FAIL collide_req got %b want 0", imem_req_valid_o); end
    step();
    redirect_i = 0;
    sample();
    n_cmp++; if (insn_valid_o !== 1'b0 || pc_o !== 32'h0 || insn_o !== 32'h0) begin n_bad++; $display("FAIL collide_empty got %b/%h/%h want 0/0/0", insn_valid_o, pc_o, insn_o); end
    n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0200_0010) begin n_bad++; $display("FAIL collide_req_next got %b/%h want 1/02000010", imem_req_valid_o, imem_addr_o); end
    step();
    sample();
    n_cmp++; if (insn_valid_o !== 1'b0) begin n_bad++; $display("FAIL collide_gap got %b want 0", insn_valid_o); end
    step();
    sample();
    n_cmp++; if (insn_valid_o !== 1'b1 || pc_o !== 32'h0200_0010) begin n_bad++; $display("FAIL collide_pc got %b/%h want 1/02000010", insn_valid_o, pc_o); end
    n_cmp++; if (insn_o !== mem_word(32'h0200_0010)) begin n_bad++; $display("FAIL collide_insn got %h want %h", insn_o, mem_word(32'h0200_0010)); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_i = 1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 0;
    sample();
    n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req0 got %b/%h want 1/fffffffc", imem_req_valid_o, imem_addr_o); end
    step();
    sample();
    n_cmp++; if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL wrap_req1 got %b/%h want 1/00000000", imem_req_valid_o, imem_addr_o); end
    step();
    sample();
    n_cmp++; if (insn_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc0 got %b/%h want 1/fffffffc", insn_valid_o, pc_o); end
    step();
    sample();
    n_cmp++; if (insn_valid_o !== 1'b1 || pc_o !== 32'h0) begin n_bad++; $display("FAIL wrap_pc1 got %b/%h want 1/00000000", insn_valid_o, pc_o); end
    n_cmp++; if (insn_o !== mem_word(32'h0)) begin n_bad++; $display("FAIL wrap_insn got %h want %h", insn_o, mem_word(32'h0)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = BASE, exp_req = BASE;
    int hs = 0;
    mem_rand = 1;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (k > 0) step();
      insn_ready_i = 1'($urandom_range(0, 1));
      sample();
      if (imem_req_valid_o && imem_req_ready_i) begin
        n_cmp++; if (imem_addr_o !== exp_req) begin n_bad++; $display("FAIL rand_req_addr cyc%0d got %h want %h", k, imem_addr_o, exp_req); end
        exp_req += 32'h4;
      end
      if (insn_valid_o && insn_ready_i) begin
        n_cmp++; if (pc_o !== exp_pc) begin n_bad++; $display("FAIL rand_pc cyc%0d got %h want %h", k, pc_o, exp_pc); end
        n_cmp++; if (insn_o !== mem_word(exp_pc)) begin n_bad++; $display("FAIL rand_insn cyc%0d got %h want %h", k, insn_o, mem_word(exp_pc)); end
        exp_pc += 32'h4;
        hs++;
      end
    end
    n_cmp++; if (hs < 40) begin n_bad++; $display("FAIL rand_progress got %0d handshakes want at least 40", hs); end
    mem_rand = 0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int hs = 0;
    do_reset();
    sample();
    n_cmp++; if (fetch_count_o !== 32'h0) begin n_bad++; $display("FAIL perf_fetch_reset got %0d want 0", fetch_count_o); end
    n_cmp++; if (flush_count_o !== 32'h0) begin n_bad++; $display("FAIL perf_flush_reset got %0d want 0", flush_count_o); end
    for (int k = 0; k < 60 && hs < 10; k++) begin
      step();
      redirect_i = k == 3 || k == 8;
      redirect_pc_i = BASE;
      sample();
      if (insn_valid_o && insn_ready_i) hs++;
    end
    step();
    redirect_i = 0;
    insn_ready_i = 0;
    sample();
    n_cmp++; if (fetch_count_o !== 32'd10) begin n_bad++; $display("FAIL perf_fetch got %0d want 10", fetch_count_o); end
    n_cmp++; if (flush_count_o !== 32'd2) begin n_bad++; $display("FAIL perf_flush got %0d want 2", flush_count_o); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_collide();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
